// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: controller<->datapath bundle; master drives enables/selects, slave drives instr, EQ, mem_ready
interface multicycle_control_fsm_if;
  logic [31:0] instr;
  logic        EQ, mem_ready;
  logic        mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, instr_retired, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUctrl;
  modport master(
    input  instr, EQ, mem_ready,
    output mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, instr_retired, illegal
  );
  modport slave(
    output instr, EQ, mem_ready,
    input  mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, instr_retired, illegal
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: RV32I multi-cycle sequencer; ports clk, rst (sync, active-high), bus (master: instr/EQ/mem_ready in, enables/selects/retire/illegal out)
module multicycle_control_fsm (
  input logic clk,
  input logic rst,
  multicycle_control_fsm_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH
  } state_t;
  state_t r_state, w_st, w_next;
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic w_r, w_addi, w_lw, w_sw, w_br;
  assign w_op   = bus.instr[6:0];
  assign w_f3   = bus.instr[14:12];
  assign w_r    = w_op == 7'b0110011 && (w_f3 == 3'b000 || w_f3 == 3'b110 || w_f3 == 3'b111);
  assign w_addi = w_op == 7'b0010011 && w_f3 == 3'b000;
  assign w_lw   = w_op == 7'b0000011 && w_f3 == 3'b010;
  assign w_sw   = w_op == 7'b0100011 && w_f3 == 3'b010;
  assign w_br   = w_op == 7'b1100011 && w_f3[2:1] == 2'b00;
  always_comb begin
    w_st              = rst ? FETCH : r_state;
    w_next            = w_st;
    bus.mem_req       = 1'b0;
    bus.AdrSrc        = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.PCWrite       = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.ResultSrc     = 2'b00;
    bus.ALUSrcA       = 2'b00;
    bus.ALUSrcB       = 2'b00;
    bus.ALUctrl       = 3'b000;
    bus.ImmSrc        = 2'b00;
    bus.instr_retired = 1'b0;
    bus.illegal       = 1'b0;
    case (w_st)
      FETCH: begin
        bus.mem_req   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = bus.mem_ready;
        bus.PCWrite   = bus.mem_ready;
        w_next        = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = 2'b10;
        bus.illegal = ~(w_r | w_addi | w_lw | w_sw | w_br);
        w_next      = w_r ? EXEC_R : w_addi ? EXEC_I : (w_lw | w_sw) ? MEM_ADDR : w_br ? BRANCH : FETCH;
      end
      EXEC_R: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUctrl = w_f3 == 3'b000 ? {2'b00, bus.instr[30]} : w_f3 == 3'b110 ? 3'b011 : 3'b010;
        w_next      = WB_ALU;
      end
      EXEC_I: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        w_next      = WB_ALU;
      end
      MEM_ADDR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = {1'b0, w_op[5]};
        w_next      = w_op[5] ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.AdrSrc  = 1'b1;
        w_next      = bus.mem_ready ? WB_MEM : MEM_RD;
      end
      MEM_WR: begin
        bus.mem_req       = 1'b1;
        bus.AdrSrc        = 1'b1;
        bus.MemWrite      = 1'b1;
        bus.instr_retired = bus.mem_ready;
        w_next            = bus.mem_ready ? FETCH : MEM_WR;
      end
      WB_ALU: begin
        bus.RegWrite      = 1'b1;
        bus.instr_retired = 1'b1;
        w_next            = FETCH;
      end
      WB_MEM: begin
        bus.ResultSrc     = 2'b01;
        bus.RegWrite      = 1'b1;
        bus.instr_retired = 1'b1;
        w_next            = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcA       = 2'b10;
        bus.ALUctrl       = 3'b001;
        bus.PCWrite       = bus.EQ ^ w_f3[0];
        bus.instr_retired = 1'b1;
        w_next            = FETCH;
      end
      default: w_next = FETCH;
    endcase
    if (rst) begin
      bus.mem_req       = 1'b0;
      bus.MemWrite      = 1'b0;
      bus.IRWrite       = 1'b0;
      bus.PCWrite       = 1'b0;
      bus.RegWrite      = 1'b0;
      bus.instr_retired = 1'b0;
      bus.illegal       = 1'b0;
    end
  end
  always_ff @(posedge clk) r_state <= rst ? FETCH : w_next;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed-vector check of the multi-cycle sequencer outputs per cycle
module tb_multicycle_control_fsm;
  logic clk, rst;
  int checks = 0, errors = 0;
  logic [18:0] w_out;
  multicycle_control_fsm_if bus();
  multicycle_control_fsm dut (.clk(clk), .rst(rst), .bus(bus));
  assign w_out = {bus.mem_req, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite,
                  bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUctrl, bus.ImmSrc,
                  bus.instr_retired, bus.illegal};
  localparam logic [18:0] RST  = {6'b000000, 6'b100010, 7'b0000000};
  localparam logic [18:0] FE1  = {6'b100110, 6'b100010, 7'b0000000};
  localparam logic [18:0] FE0  = {6'b100000, 6'b100010, 7'b0000000};
  localparam logic [18:0] DEC  = {6'b000000, 6'b000101, 7'b0001000};
  localparam logic [18:0] ILL  = {6'b000000, 6'b000101, 7'b0001001};
  localparam logic [18:0] EXI  = {6'b000000, 6'b001001, 7'b0000000};
  localparam logic [18:0] EXAD = {6'b000000, 6'b001000, 7'b0000000};
  localparam logic [18:0] EXSB = {6'b000000, 6'b001000, 7'b0010000};
  localparam logic [18:0] EXOR = {6'b000000, 6'b001000, 7'b0110000};
  localparam logic [18:0] EXAN = {6'b000000, 6'b001000, 7'b0100000};
  localparam logic [18:0] WBA  = {6'b000001, 6'b000000, 7'b0000010};
  localparam logic [18:0] MAL  = {6'b000000, 6'b001001, 7'b0000000};
  localparam logic [18:0] MAS  = {6'b000000, 6'b001001, 7'b0000100};
  localparam logic [18:0] MRD  = {6'b110000, 6'b000000, 7'b0000000};
  localparam logic [18:0] MWR0 = {6'b111000, 6'b000000, 7'b0000000};
  localparam logic [18:0] MWR1 = {6'b111000, 6'b000000, 7'b0000010};
  localparam logic [18:0] WBM  = {6'b000001, 6'b010000, 7'b0000010};
  localparam logic [18:0] BR0  = {6'b000000, 6'b001000, 7'b0010010};
  localparam logic [18:0] BR1  = {6'b000010, 6'b001000, 7'b0010010};
  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic r, input logic mr, input logic eq, input logic [18:0] exp);
    rst = r;
    bus.mem_ready = mr;
    bus.EQ = eq;
    @(negedge clk);
    check(tag, w_out, exp);
    @(posedge clk);
    #1;
  endtask
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    rst = 1;
    bus.mem_ready = 1;
    bus.EQ = 0;
    bus.instr = 32'h00500093;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc("reset", 1, 1, 0, RST);
    cyc("addi_fetch", 0, 1, 0, FE1);
    cyc("addi_decode", 0, 1, 0, DEC);
    cyc("addi_exec", 0, 1, 0, EXI);
    cyc("addi_wb", 0, 1, 0, WBA);
    bus.instr = 32'h0040A103;
    cyc("lw_fetch", 0, 1, 0, FE1);
    cyc("lw_decode", 0, 1, 0, DEC);
    cyc("lw_addr", 0, 1, 0, MAL);
    cyc("lw_rd_wait1", 0, 0, 0, MRD);
    cyc("lw_rd_wait2", 0, 0, 0, MRD);
    cyc("lw_rd_done", 0, 1, 0, MRD);
    cyc("lw_wb", 0, 1, 0, WBM);
    bus.instr = 32'h0020A423;
    cyc("sw_fetch_wait", 0, 0, 0, FE0);
    cyc("sw_fetch", 0, 1, 0, FE1);
    cyc("sw_decode", 0, 0, 0, DEC);
    cyc("sw_addr", 0, 0, 0, MAS);
    cyc("sw_wr", 0, 1, 0, MWR1);
    bus.instr = 32'h00209063;
    cyc("bne_eq_fetch", 0, 1, 1, FE1);
    cyc("bne_eq_decode", 0, 1, 1, DEC);
    cyc("bne_eq_branch", 0, 1, 1, BR0);
    cyc("bne_ne_fetch", 0, 1, 0, FE1);
    cyc("bne_ne_decode", 0, 1, 0, DEC);
    cyc("bne_ne_branch", 0, 1, 0, BR1);
    bus.instr = 32'h00208063;
    cyc("beq_fetch", 0, 1, 1, FE1);
    cyc("beq_decode", 0, 1, 1, DEC);
    cyc("beq_eq_branch", 0, 1, 1, BR1);
    cyc("beq_fetch2", 0, 1, 0, FE1);
    cyc("beq_decode2", 0, 1, 0, DEC);
    cyc("beq_ne_branch", 0, 1, 0, BR0);
    bus.instr = 32'h402081B3;
    cyc("sub_fetch", 0, 1, 0, FE1);
    cyc("sub_decode", 0, 1, 0, DEC);
    cyc("sub_exec", 0, 1, 0, EXSB);
    cyc("sub_wb", 0, 1, 0, WBA);
    bus.instr = 32'h0020E1B3;
    cyc("or_fetch", 0, 1, 0, FE1);
    cyc("or_decode", 0, 1, 0, DEC);
    cyc("or_exec", 0, 1, 0, EXOR);
    cyc("or_wb", 0, 1, 0, WBA);
    bus.instr = 32'h0020F1B3;
    cyc("and_fetch", 0, 1, 0, FE1);
    cyc("and_decode", 0, 1, 0, DEC);
    cyc("and_exec", 0, 1, 0, EXAN);
    cyc("and_wb", 0, 1, 0, WBA);
    bus.instr = 32'h002081B3;
    cyc("add_fetch", 0, 1, 0, FE1);
    cyc("add_decode", 0, 1, 0, DEC);
    cyc("add_exec", 0, 1, 0, EXAD);
    cyc("add_wb", 0, 1, 0, WBA);
    bus.instr = 32'h0000007F;
    cyc("ill_fetch", 0, 1, 0, FE1);
    cyc("ill_decode", 0, 1, 0, ILL);
    bus.instr = 32'h00000003;
    cyc("ill_refetch", 0, 1, 0, FE1);
    cyc("lb_decode", 0, 1, 0, ILL);
    bus.instr = 32'h0020A423;
    cyc("rsw_fetch", 0, 1, 0, FE1);
    cyc("rsw_decode", 0, 1, 0, DEC);
    cyc("rsw_addr", 0, 1, 0, MAS);
    cyc("rsw_wait", 0, 0, 0, MWR0);
    cyc("rsw_reset", 1, 0, 0, RST);
    cyc("rsw_after_reset", 0, 1, 0, FE1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
